// File: rtl/fwd_pkg.sv
// -----------------------------------------------------------------------------
// fwd_pkg
// Shared definitions for the route_dispatch slice.
//   - Forwarding descriptor layout (DESC_WIDTH = 224). Fields are packed from
//     the MSB down in the order pkt_id, src_qp, out_port, out_qp, nh_ip,
//     nh_port, nh_qp, nh_mac, drop, bcast, direct. Everything below the direct
//     flag is zero padding.
//   - Context word layout (32 bits): {pkt_id, src_qp}.
//   - Indices into the sticky error flag vector.
// No ports (package).
// -----------------------------------------------------------------------------
package fwd_pkg;

   localparam int DESC_WIDTH = 224;
   localparam int CTX_WIDTH  = 32;

   localparam int TAG_W = 16;
   localparam int IP_W  = 32;
   localparam int MAC_W = 48;

   // Descriptor field LSB offsets
   localparam int PKT_ID_LSB   = 208;
   localparam int SRC_QP_LSB   = 192;
   localparam int OUT_PORT_LSB = 176;
   localparam int OUT_QP_LSB   = 160;
   localparam int NH_IP_LSB    = 128;
   localparam int NH_PORT_LSB  = 112;
   localparam int NH_QP_LSB    = 96;
   localparam int NH_MAC_LSB   = 48;
   localparam int DROP_BIT     = 47;
   localparam int BCAST_BIT    = 46;
   localparam int DIRECT_BIT   = 45;

   // Context word offsets
   localparam int CTX_PKT_LSB = 16;
   localparam int CTX_QP_LSB  = 0;

   // Sticky error flag indices
   localparam int ERR_W          = 2;
   localparam int ERR_UNEXPECTED = 0;
   localparam int ERR_TIMEOUT    = 1;

   function automatic logic [CTX_WIDTH-1:0] make_ctx(input logic [TAG_W-1:0] pkt_id,
                                                     input logic [TAG_W-1:0] src_qp);
      return {pkt_id, src_qp};
   endfunction

endpackage

// File: rtl/dispatch_fifo.sv
// -----------------------------------------------------------------------------
// dispatch_fifo
// Synchronous FIFO, parameterised width and depth (DEPTH a power of two).
// Storage, pointers and occupancy are all flops. rd_data always shows the
// head entry, so it only changes on a pop or on the first push after empty.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   push, push_data      write request (ignored when full unless popping)
//   pop                  read request (ignored when empty)
//   rd_data              head entry
//   full, empty, count   occupancy status
// -----------------------------------------------------------------------------
module dispatch_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   assign rd_data = mem[rd_ptr];
   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);

endmodule

// File: rtl/route_dispatch.sv
// -----------------------------------------------------------------------------
// route_dispatch
// Ingress client of the router lookup block. Accepts headers (valid/ready),
// issues one lookup per header, merges each in-order router response with the
// stored {pkt_id, src_qp} context into a 224-bit forwarding descriptor and
// buffers it for the egress scheduler (valid/ready).
//
// Handshakes: a transfer happens in any cycle where valid && ready are both
// high at the clock edge; valid/data are held until the transfer.
//
// The router cannot be stalled, so one descriptor slot (a credit) is reserved
// at accept time and returned only when that descriptor leaves. in_ready is
// derived from flops only (registered router_init_done and the credit count).
//
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   router_init_done                   router table loaded
//   in_valid/in_ready, in_dst_ip,
//   in_src_qp, in_pkt_id               header input
//   lookup_valid, lookup_dst_ip        registered lookup request to router
//   resp_*                             router response (LOOKUP_LATENCY after lookup)
//   out_valid/out_ready, out_desc      descriptor output
//   err_unexpected_resp, err_timeout   sticky error flags
// Optional build macro ROUTE_DISPATCH_STATS_EN adds stat_lookups, stat_misses
// and stat_bcast (32-bit wrap-around counters).
// -----------------------------------------------------------------------------
module route_dispatch
   import fwd_pkg::*;
#(
   parameter int FIFO_DEPTH     = 8,
   parameter int LOOKUP_LATENCY = 2,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  router_init_done,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [31:0]           in_dst_ip,
   input  logic [15:0]           in_src_qp,
   input  logic [15:0]           in_pkt_id,
   output logic                  lookup_valid,
   output logic [31:0]           lookup_dst_ip,
   input  logic                  resp_valid,
   input  logic                  resp_found,
   input  logic                  resp_is_direct_host,
   input  logic                  resp_is_broadcast,
   input  logic [15:0]           resp_out_port,
   input  logic [15:0]           resp_out_qp,
   input  logic [15:0]           resp_next_hop_port,
   input  logic [15:0]           resp_next_hop_qp,
   input  logic [31:0]           resp_next_hop_ip,
   input  logic [47:0]           resp_next_hop_mac,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DESC_WIDTH-1:0] out_desc,
   output logic                  err_unexpected_resp,
   output logic                  err_timeout
`ifdef ROUTE_DISPATCH_STATS_EN
   ,
   output logic [31:0]           stat_lookups,
   output logic [31:0]           stat_misses,
   output logic [31:0]           stat_bcast
`endif
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic                  init_q;
   logic [CNT_W-1:0]      credits_used;
   logic [TMO_W-1:0]      tmo_cnt;
   logic [ERR_W-1:0]      err_q;

   logic                  accept;
   logic                  resp_hit;
   logic                  tmo_fire;
   logic                  ctx_pop;
   logic                  desc_pop;
   logic                  resp_drop;
   logic [DESC_WIDTH-1:0] new_desc;

   logic [CTX_WIDTH-1:0]  ctx_rd;
   logic                  ctx_full;
   logic                  ctx_empty;
   logic [CNT_W-1:0]      ctx_count;
   logic                  desc_full;
   logic                  desc_empty;
   logic [CNT_W-1:0]      desc_count;
   logic                  unused_fifo_status;

   // Occupancy outputs this instance does not need.
   assign unused_fifo_status = ^{ctx_count, desc_count, desc_full};

   // ctx_full can only be reached with all credits taken; it is kept as a
   // belt-and-braces guard on the context push.
   assign in_ready = init_q && !ctx_full && (credits_used < CNT_W'(FIFO_DEPTH));
   assign accept   = in_valid && in_ready;
   assign resp_hit = resp_valid && !ctx_empty;
   // A response arriving in the expiry cycle wins over the timeout.
   assign tmo_fire = !ctx_empty && !resp_valid && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES));
   assign ctx_pop  = resp_hit || tmo_fire;
   assign out_valid = !desc_empty;
   assign desc_pop  = out_valid && out_ready;

   dispatch_fifo #(.WIDTH(CTX_WIDTH), .DEPTH(FIFO_DEPTH)) u_ctx_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (accept),
      .push_data (make_ctx(in_pkt_id, in_src_qp)),
      .pop       (ctx_pop),
      .rd_data   (ctx_rd),
      .full      (ctx_full),
      .empty     (ctx_empty),
      .count     (ctx_count)
   );

   dispatch_fifo #(.WIDTH(DESC_WIDTH), .DEPTH(FIFO_DEPTH)) u_desc_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (ctx_pop),
      .push_data (new_desc),
      .pop       (desc_pop),
      .rd_data   (out_desc),
      .full      (desc_full),
      .empty     (desc_empty),
      .count     (desc_count)
   );

   // Descriptor merge. A timed-out context takes the default path: drop=1
   // with every route field zero.
   always_comb begin
      new_desc  = '0;
      resp_drop = 1'b1;
      new_desc[PKT_ID_LSB +: TAG_W] = ctx_rd[CTX_PKT_LSB +: TAG_W];
      new_desc[SRC_QP_LSB +: TAG_W] = ctx_rd[CTX_QP_LSB +: TAG_W];
      if (resp_hit) begin
         resp_drop            = !resp_found && !resp_is_broadcast;
         new_desc[BCAST_BIT]  = resp_is_broadcast;
         new_desc[DIRECT_BIT] = resp_is_direct_host;
         if (!resp_drop) begin
            new_desc[OUT_PORT_LSB +: TAG_W] = resp_out_port;
            new_desc[OUT_QP_LSB   +: TAG_W] = resp_out_qp;
            new_desc[NH_IP_LSB    +: IP_W]  = resp_next_hop_ip;
            new_desc[NH_PORT_LSB  +: TAG_W] = resp_next_hop_port;
            new_desc[NH_QP_LSB    +: TAG_W] = resp_next_hop_qp;
            new_desc[NH_MAC_LSB   +: MAC_W] = resp_next_hop_mac;
         end
      end
      new_desc[DROP_BIT] = resp_drop;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         init_q        <= 1'b0;
         credits_used  <= '0;
         tmo_cnt       <= '0;
         err_q         <= '0;
         lookup_valid  <= 1'b0;
         lookup_dst_ip <= '0;
      end else begin
         init_q       <= router_init_done;
         lookup_valid <= accept;
         if (accept) lookup_dst_ip <= in_dst_ip;

         case ({accept, desc_pop})
            2'b10:   credits_used <= credits_used + CNT_W'(1);
            2'b01:   credits_used <= credits_used - CNT_W'(1);
            default: credits_used <= credits_used;
         endcase

         if (ctx_empty || resp_valid || tmo_fire) tmo_cnt <= '0;
         else                                     tmo_cnt <= tmo_cnt + TMO_W'(1);

         if (resp_valid && ctx_empty) err_q[ERR_UNEXPECTED] <= 1'b1;
         if (tmo_fire)                err_q[ERR_TIMEOUT]    <= 1'b1;
      end
   end

   assign err_unexpected_resp = err_q[ERR_UNEXPECTED];
   assign err_timeout         = err_q[ERR_TIMEOUT];

`ifdef ROUTE_DISPATCH_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_lookups <= '0;
         stat_misses  <= '0;
         stat_bcast   <= '0;
      end else begin
         if (accept)                         stat_lookups <= stat_lookups + 32'd1;
         if (ctx_pop && new_desc[DROP_BIT])  stat_misses  <= stat_misses + 32'd1;
         if (ctx_pop && new_desc[BCAST_BIT]) stat_bcast   <= stat_bcast + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_route_dispatch.sv
// -----------------------------------------------------------------------------
// tb_route_dispatch
// Bench for route_dispatch with a fixed-latency in-order router mock.
// Mock response classes, keyed by the top byte of the destination IP:
//   0xEE miss (found=0, bcast=0), 0xBB broadcast (found=0, bcast=1),
//   0xDD response suppressed, anything else found=1 (direct = dst[8]).
// -----------------------------------------------------------------------------
module tb_route_dispatch;

   typedef struct packed {
      logic        found;
      logic        direct;
      logic        bcast;
      logic [15:0] op;
      logic [15:0] oq;
      logic [15:0] np;
      logic [15:0] nq;
      logic [31:0] nip;
      logic [47:0] mac;
   } resp_t;

   logic         clk;
   logic         rst_n;
   logic         router_init_done;
   logic         in_valid;
   logic         in_ready;
   logic [31:0]  in_dst_ip;
   logic [15:0]  in_src_qp;
   logic [15:0]  in_pkt_id;
   logic         lookup_valid;
   logic [31:0]  lookup_dst_ip;
   logic         resp_valid;
   logic         resp_found;
   logic         resp_is_direct_host;
   logic         resp_is_broadcast;
   logic [15:0]  resp_out_port;
   logic [15:0]  resp_out_qp;
   logic [15:0]  resp_next_hop_port;
   logic [15:0]  resp_next_hop_qp;
   logic [31:0]  resp_next_hop_ip;
   logic [47:0]  resp_next_hop_mac;
   logic         out_valid;
   logic         out_ready;
   logic [223:0] out_desc;
   logic         err_unexpected_resp;
   logic         err_timeout;
`ifdef ROUTE_DISPATCH_STATS_EN
   logic [31:0]  stat_lookups;
   logic [31:0]  stat_misses;
   logic [31:0]  stat_bcast;
`endif

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   logic spur_req = 1'b0;

   logic [223:0] exp_q[$];
   logic [223:0] got_q[$];
   int           got_t[$];

   route_dispatch dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .router_init_done    (router_init_done),
      .in_valid            (in_valid),
      .in_ready            (in_ready),
      .in_dst_ip           (in_dst_ip),
      .in_src_qp           (in_src_qp),
      .in_pkt_id           (in_pkt_id),
      .lookup_valid        (lookup_valid),
      .lookup_dst_ip       (lookup_dst_ip),
      .resp_valid          (resp_valid),
      .resp_found          (resp_found),
      .resp_is_direct_host (resp_is_direct_host),
      .resp_is_broadcast   (resp_is_broadcast),
      .resp_out_port       (resp_out_port),
      .resp_out_qp         (resp_out_qp),
      .resp_next_hop_port  (resp_next_hop_port),
      .resp_next_hop_qp    (resp_next_hop_qp),
      .resp_next_hop_ip    (resp_next_hop_ip),
      .resp_next_hop_mac   (resp_next_hop_mac),
      .out_valid           (out_valid),
      .out_ready           (out_ready),
      .out_desc            (out_desc),
      .err_unexpected_resp (err_unexpected_resp),
      .err_timeout         (err_timeout)
`ifdef ROUTE_DISPATCH_STATS_EN
      ,
      .stat_lookups        (stat_lookups),
      .stat_misses         (stat_misses),
      .stat_bcast          (stat_bcast)
`endif
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- router mock and reference model ----------------
   function automatic resp_t mock_resp(input logic [31:0] dst);
      resp_t r;
      r.found  = 1'b1;
      r.bcast  = 1'b0;
      r.direct = dst[8];
      if (dst[31:24] == 8'hEE) begin r.found = 1'b0; r.direct = 1'b0; end
      if (dst[31:24] == 8'hBB) begin r.found = 1'b0; r.bcast = 1'b1; r.direct = 1'b0; end
      r.op  = {8'h00, dst[7:0]} + 16'd1;
      r.oq  = dst[15:0] ^ 16'h5555;
      r.np  = 16'h0007;
      r.nq  = dst[23:8];
      r.nip = dst ^ 32'h01010101;
      r.mac = 48'h001122334453 + {40'd0, dst[7:0]};
      return r;
   endfunction

   function automatic logic [223:0] model(input logic [31:0] dst, input logic [15:0] pkt,
                                          input logic [15:0] src);
      logic [223:0] d;
      resp_t r;
      logic drop;
      r = mock_resp(dst);
      d = '0;
      d[223:208] = pkt;
      d[207:192] = src;
      if (dst[31:24] == 8'hDD) begin
         d[47] = 1'b1;
      end else begin
         drop  = !r.found && !r.bcast;
         d[47] = drop;
         d[46] = r.bcast;
         d[45] = r.direct;
         if (!drop) begin
            d[191:176] = r.op;
            d[175:160] = r.oq;
            d[159:128] = r.nip;
            d[127:112] = r.np;
            d[111:96]  = r.nq;
            d[95:48]   = r.mac;
         end
      end
      return d;
   endfunction

   // Responds two cycles after lookup_valid is seen.
   initial begin : router_mock
      logic p0_v, p1_v;
      logic [31:0] p0_d, p1_d;
      resp_t r;
      p0_v = 1'b0; p1_v = 1'b0; p0_d = '0; p1_d = '0;
      resp_valid = 1'b0; resp_found = 1'b0; resp_is_direct_host = 1'b0;
      resp_is_broadcast = 1'b0; resp_out_port = '0; resp_out_qp = '0;
      resp_next_hop_port = '0; resp_next_hop_qp = '0; resp_next_hop_ip = '0;
      resp_next_hop_mac = '0;
      forever begin
         @(posedge clk);
         #1;
         r = mock_resp(p1_d);
         resp_valid = 1'b0;
         if (p1_v && p1_d[31:24] != 8'hDD) begin
            resp_valid = 1'b1;
         end else if (spur_req) begin
            resp_valid = 1'b1;
            spur_req   = 1'b0;
         end
         resp_found          = resp_valid && r.found;
         resp_is_broadcast   = resp_valid && r.bcast;
         resp_is_direct_host = resp_valid && r.direct;
         resp_out_port       = resp_valid ? r.op  : '0;
         resp_out_qp         = resp_valid ? r.oq  : '0;
         resp_next_hop_port  = resp_valid ? r.np  : '0;
         resp_next_hop_qp    = resp_valid ? r.nq  : '0;
         resp_next_hop_ip    = resp_valid ? r.nip : '0;
         resp_next_hop_mac   = resp_valid ? r.mac : '0;
         p1_v = p0_v; p1_d = p0_d;
         p0_v = lookup_valid; p0_d = lookup_dst_ip;
      end
   end

   // ---------------- scoreboard capture ----------------
   initial begin : capture
      forever begin
         @(negedge clk);
         #2;
         if (rst_n && in_valid && in_ready) exp_q.push_back(model(in_dst_ip, in_pkt_id, in_src_qp));
         if (rst_n && out_valid && out_ready) begin
            got_q.push_back(out_desc);
            got_t.push_back(cyc);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive_hdr(input logic [31:0] dst, input logic [15:0] pkt, input logic [15:0] src);
      in_valid  = 1'b1;
      in_dst_ip = dst;
      in_pkt_id = pkt;
      in_src_qp = src;
   endtask

   task automatic clear_sb();
      exp_q.delete();
      got_q.delete();
      got_t.delete();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b1; router_init_done = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      in_dst_ip = '0; in_pkt_id = '0; in_src_qp = '0;
      #1 rst_n = 1'b0;
      #2;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
      checks++; if (lookup_valid !== 1'b0) begin failures++; $display("FAIL reset_lookup_valid got=%b exp=0", lookup_valid); end
      checks++; if (lookup_dst_ip !== 32'h0) begin failures++; $display("FAIL reset_lookup_dst got=%h exp=0", lookup_dst_ip); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++; if (out_desc !== 224'h0) begin failures++; $display("FAIL reset_out_desc got=%h exp=0", out_desc); end
      checks++; if ({err_unexpected_resp, err_timeout} !== 2'b00) begin failures++; $display("FAIL reset_errs got=%b exp=00", {err_unexpected_resp, err_timeout}); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready_after got=%b exp=1", in_ready); end
   endtask

   task automatic test_single();
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL single_ready got=%b exp=1", in_ready); end
      drive_hdr(32'h0A000002, 16'h0011, 16'h0022);
      @(negedge clk);
      in_valid = 1'b0;
      checks++; if (lookup_valid !== 1'b1) begin failures++; $display("FAIL single_lookup_valid got=%b exp=1", lookup_valid); end
      checks++; if (lookup_dst_ip !== 32'h0A000002) begin failures++; $display("FAIL single_lookup_dst got=%h exp=0a000002", lookup_dst_ip); end
      @(negedge clk);
      checks++; if (lookup_valid !== 1'b0) begin failures++; $display("FAIL single_lookup_pulse got=%b exp=0", lookup_valid); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_early_t2 got=%b exp=0", out_valid); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_early_t3 got=%b exp=0", out_valid); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL single_valid_t4 got=%b exp=1", out_valid); end
      checks++; if (out_desc[223:208] !== 16'h0011) begin failures++; $display("FAIL single_pkt_id got=%h exp=0011", out_desc[223:208]); end
      checks++; if (out_desc[207:192] !== 16'h0022) begin failures++; $display("FAIL single_src_qp got=%h exp=0022", out_desc[207:192]); end
      checks++; if (out_desc[191:176] !== 16'h0003) begin failures++; $display("FAIL single_out_port got=%h exp=0003", out_desc[191:176]); end
      checks++; if (out_desc[95:48] !== 48'h001122334455) begin failures++; $display("FAIL single_nh_mac got=%h exp=001122334455", out_desc[95:48]); end
      checks++; if (out_desc[47] !== 1'b0) begin failures++; $display("FAIL single_drop got=%b exp=0", out_desc[47]); end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_popped got=%b exp=0", out_valid); end
      checks++; if (got_q.size() != 1 || exp_q.size() != 1) begin failures++; $display("FAIL single_count got=%0d exp=1", got_q.size()); end
      else begin
         checks++; if (got_q[0] !== exp_q[0]) begin failures++; $display("FAIL single_desc got=%h exp=%h", got_q[0], exp_q[0]); end
      end
      clear_sb();
   endtask

   task automatic test_init_done();
      @(negedge clk);
      router_init_done = 1'b0;
      @(negedge clk);
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL init_ready_drop got=%b exp=0", in_ready); end
      drive_hdr(32'h0A000107, 16'h0077, 16'h0078);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++; if (in_ready !== 1'b0 || lookup_valid !== 1'b0) begin failures++; $display("FAIL init_blocked got=%b%b exp=00", in_ready, lookup_valid); end
      end
      router_init_done = 1'b1;
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL init_ready_rise got=%b exp=1", in_ready); end
      @(negedge clk);
      in_valid = 1'b0;
      checks++; if (lookup_valid !== 1'b1) begin failures++; $display("FAIL init_lookup got=%b exp=1", lookup_valid); end
      out_ready = 1'b1;
      for (int k = 0; k < 20 && got_q.size() < 1; k++) @(negedge clk);
      out_ready = 1'b0;
      checks++; if (got_q.size() != 1 || exp_q.size() != 1) begin failures++; $display("FAIL init_count got=%0d/%0d exp=1", got_q.size(), exp_q.size()); end
      else begin
         checks++; if (got_q[0] !== exp_q[0]) begin failures++; $display("FAIL init_desc got=%h exp=%h", got_q[0], exp_q[0]); end
         checks++; if (got_q[0][45] !== 1'b1) begin failures++; $display("FAIL init_direct got=%b exp=1", got_q[0][45]); end
      end
      clear_sb();
   endtask

   task automatic test_backpressure();
      int n;
      n = 0;
      out_ready = 1'b0;
      for (int c = 0; c < 16 && n < 10; c++) begin
         @(negedge clk);
         drive_hdr(32'h0C000000 | n, 16'h0300 + n[15:0], 16'h0030 + n[15:0]);
         if (in_ready) n++;
      end
      checks++; if (n != 8) begin failures++; $display("FAIL bp_accepts got=%0d exp=8", n); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_low got=%b exp=0", in_ready); end
      @(negedge clk);
      drive_hdr(32'h0C000000 | n, 16'h0300 + n[15:0], 16'h0030 + n[15:0]);
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_pulse got=%b exp=0", in_ready); end
      out_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         out_ready = 1'b0;
         drive_hdr(32'h0C000000 | n, 16'h0300 + n[15:0], 16'h0030 + n[15:0]);
         if (in_ready) n++;
      end
      @(negedge clk);
      in_valid = 1'b0;
      checks++; if (n != 9) begin failures++; $display("FAIL bp_extra_accept got=%0d exp=9", n); end
      out_ready = 1'b1;
      for (int k = 0; k < 40 && got_q.size() < 9; k++) @(negedge clk);
      out_ready = 1'b0;
      checks++; if (got_q.size() != 9 || exp_q.size() != 9) begin failures++; $display("FAIL bp_count got=%0d/%0d exp=9", got_q.size(), exp_q.size()); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL bp_desc_%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
      end
      clear_sb();
   endtask

   task automatic test_miss_bcast();
      out_ready = 1'b1;
      @(negedge clk);
      drive_hdr(32'hEE123456, 16'h0041, 16'h0042);
      @(negedge clk);
      drive_hdr(32'hBB000009, 16'h0043, 16'h0044);
      @(negedge clk);
      in_valid = 1'b0;
      for (int k = 0; k < 20 && got_q.size() < 2; k++) @(negedge clk);
      checks++; if (got_q.size() != 2) begin failures++; $display("FAIL miss_count got=%0d exp=2", got_q.size()); end
      else begin
         checks++; if (got_q[0][223:208] !== 16'h0041) begin failures++; $display("FAIL miss_pkt got=%h exp=0041", got_q[0][223:208]); end
         checks++; if (got_q[0][47] !== 1'b1) begin failures++; $display("FAIL miss_drop got=%b exp=1", got_q[0][47]); end
         checks++; if (got_q[0][191:48] !== 144'h0) begin failures++; $display("FAIL miss_fields_zero got=%h exp=0", got_q[0][191:48]); end
         checks++; if (got_q[1][47:46] !== 2'b01) begin failures++; $display("FAIL bcast_flags got=%b exp=01", got_q[1][47:46]); end
         checks++; if (got_q[1][191:176] !== 16'h000A) begin failures++; $display("FAIL bcast_port got=%h exp=000a", got_q[1][191:176]); end
         for (int i = 0; i < 2 && i < exp_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL missb_desc_%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
         end
      end
      out_ready = 1'b0;
      clear_sb();
   endtask

   task automatic test_timeout_spurious();
      out_ready = 1'b1;
      @(negedge clk);
      drive_hdr(32'hDD000001, 16'h0055, 16'h0066);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (11) @(negedge clk);
      checks++; if (err_timeout !== 1'b0) begin failures++; $display("FAIL tmo_early got=%b exp=0", err_timeout); end
      checks++; if (got_q.size() != 0) begin failures++; $display("FAIL tmo_early_desc got=%0d exp=0", got_q.size()); end
      for (int k = 0; k < 30 && got_q.size() < 1; k++) @(negedge clk);
      checks++; if (err_timeout !== 1'b1) begin failures++; $display("FAIL tmo_flag got=%b exp=1", err_timeout); end
      checks++; if (got_q.size() != 1) begin failures++; $display("FAIL tmo_count got=%0d exp=1", got_q.size()); end
      else begin
         checks++; if (got_q[0][223:208] !== 16'h0055) begin failures++; $display("FAIL tmo_pkt got=%h exp=0055", got_q[0][223:208]); end
         checks++; if (got_q[0][47] !== 1'b1) begin failures++; $display("FAIL tmo_drop got=%b exp=1", got_q[0][47]); end
         checks++; if (got_q[0] !== exp_q[0]) begin failures++; $display("FAIL tmo_desc got=%h exp=%h", got_q[0], exp_q[0]); end
      end
      checks++; if (err_unexpected_resp !== 1'b0) begin failures++; $display("FAIL spur_before got=%b exp=0", err_unexpected_resp); end
      spur_req = 1'b1;
      repeat (4) @(negedge clk);
      checks++; if (err_unexpected_resp !== 1'b1) begin failures++; $display("FAIL spur_flag got=%b exp=1", err_unexpected_resp); end
      checks++; if (got_q.size() != 1 || out_valid !== 1'b0) begin failures++; $display("FAIL spur_no_desc got=%0d/%b exp=1/0", got_q.size(), out_valid); end
      out_ready = 1'b0;
      clear_sb();
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_%0d got=%b exp=1", i, in_ready); end
         drive_hdr(32'h14000100 + i, 16'h0500 + i[15:0], 16'h0600 + i[15:0]);
      end
      @(negedge clk);
      in_valid = 1'b0;
      for (int k = 0; k < 30 && got_q.size() < 12; k++) @(negedge clk);
      checks++; if (got_q.size() != 12 || exp_q.size() != 12) begin failures++; $display("FAIL b2b_count got=%0d/%0d exp=12", got_q.size(), exp_q.size()); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL b2b_desc_%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
      end
      for (int i = 1; i < got_t.size(); i++) begin
         checks++; if (got_t[i] != got_t[i-1] + 1) begin failures++; $display("FAIL b2b_gap_%0d got=%0d exp=%0d", i, got_t[i], got_t[i-1] + 1); end
      end
      clear_sb();
   endtask

   task automatic test_reset_midstream();
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         drive_hdr(32'h0A000020 + i, 16'h0700 + i[15:0], 16'h0800 + i[15:0]);
      end
      @(negedge clk);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      checks++; if ({in_ready, lookup_valid, out_valid} !== 3'b000) begin failures++; $display("FAIL mid_rst_ctrl got=%b exp=000", {in_ready, lookup_valid, out_valid}); end
      checks++; if (out_desc !== 224'h0 || lookup_dst_ip !== 32'h0) begin failures++; $display("FAIL mid_rst_data got=%h/%h exp=0", out_desc, lookup_dst_ip); end
      checks++; if ({err_unexpected_resp, err_timeout} !== 2'b00) begin failures++; $display("FAIL mid_rst_errs got=%b exp=00", {err_unexpected_resp, err_timeout}); end
      @(negedge clk);
      rst_n = 1'b1;
      clear_sb();
      repeat (4) @(negedge clk);
      checks++; if (err_unexpected_resp !== 1'b1) begin failures++; $display("FAIL mid_late_resp got=%b exp=1", err_unexpected_resp); end
      checks++; if (out_valid !== 1'b0 || got_q.size() != 0) begin failures++; $display("FAIL mid_fifo_empty got=%b/%0d exp=0/0", out_valid, got_q.size()); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL mid_ready got=%b exp=1", in_ready); end
      out_ready = 1'b0;
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_single();
      test_init_done();
      test_backpressure();
      test_miss_bcast();
      test_timeout_spurious();
      test_back_to_back();
      test_reset_midstream();
      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
